// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
// Holds the arbiter state encoding and the MEM-stage control field layout.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_e;

  // Bit positions inside the 2-bit MEM-stage control field
  localparam int MEM_CTRL_EN = 1;
  localparam int MEM_CTRL_WR = 0;

  localparam logic [1:0] MEM_CTRL_RD    = 2'b10;
  localparam logic [1:0] MEM_CTRL_WR_OP = 2'b11;

  // Wide enough for the largest legal MEM_LAT of 15
  localparam int CNT_W = 4;

  function automatic logic mem_ctrl_is_req(input logic [1:0] ctrl);
    return ctrl[MEM_CTRL_EN];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM requesters plus RAM) and the arbiter.
// The arbiter uses the slave view; the surrounding pipeline/RAM uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic [1:0]        mem_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, mem_ctrl, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_ctrl, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Clear/enable cycle counter that flags the last cycle of a RAM access.
// Clear has priority over enable so a completing access restarts from zero.
module lat_counter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the MEM stage,
// holding each access for MEM_LAT cycles and alternating grants under contention.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q,     state_d;
  logic              last_mem_q,  last_mem_d;
  logic              ram_en_q,    ram_en_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              mem_ack_q,   mem_ack_d;

  logic if_elig;
  logic mem_elig;
  logic grant_if;
  logic grant_mem;
  logic busy;
  logic cnt_clr;
  logic cnt_tc;

  // A requester being acked this cycle must not be re-granted on the same request
  assign if_elig   = bus.if_req && !if_ack_q;
  assign mem_elig  = mem_ctrl_is_req(bus.mem_ctrl) && !mem_ack_q;
  assign grant_mem = mem_elig && (!if_elig || !last_mem_q);
  assign grant_if  = if_elig && (!mem_elig || last_mem_q);

  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
  assign cnt_clr = busy && cnt_tc;

  lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (busy),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d     = BUSY_MEM;
          last_mem_d  = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.mem_ctrl[MEM_CTRL_WR];
          ram_addr_d  = bus.mem_addr;
          ram_wdata_d = bus.mem_wdata;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          last_mem_d  = 1'b0;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = bus.if_addr;
          ram_wdata_d = '0;
        end
      end

      BUSY_IF: begin
        if (cnt_tc) begin
          state_d    = IDLE;
          ram_en_d   = 1'b0;
          ram_we_d   = 1'b0;
          if_rdata_d = bus.ram_rdata;
          if_ack_d   = 1'b1;
        end
      end

      BUSY_MEM: begin
        if (cnt_tc) begin
          state_d   = IDLE;
          ram_en_d  = 1'b0;
          ram_we_d  = 1'b0;
          mem_ack_d = 1'b1;
          if (!ram_we_q) begin
            mem_rdata_d = bus.ram_rdata;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_ack   = mem_ack_q;

  // Stalls are combinational so the hazard unit sees a new request immediately
  assign bus.stall_if  = bus.if_req && !if_ack_q;
  assign bus.stall_mem = mem_ctrl_is_req(bus.mem_ctrl) && !mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-timestamp model of the arbiter.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: one outstanding transaction described by its grant cycle
  bit          m_act;
  int          m_g;
  bit          m_own_mem;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;
  bit          m_last_mem;
  int          m_if_ack_c, m_mem_ack_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_g = -100; m_own_mem = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
    m_last_mem = 0; m_if_ack_c = -1; m_mem_ack_c = -1;
  endtask

  task automatic check_outputs();
    bit en;
    en = m_act && (cyc > m_g) && (cyc <= m_g + LAT);
    chk("ram_en",    32'(bus.ram_en),    32'(en));
    chk("ram_we",    32'(bus.ram_we),    32'(en && m_we));
    chk("ram_addr",  bus.ram_addr,       m_addr);
    chk("ram_wdata", bus.ram_wdata,      m_wdata);
    chk("if_ack",    32'(bus.if_ack),    32'(cyc == m_if_ack_c));
    chk("mem_ack",   32'(bus.mem_ack),   32'(cyc == m_mem_ack_c));
    chk("if_rdata",  bus.if_rdata,       m_if_rd);
    chk("mem_rdata", bus.mem_rdata,      m_mem_rd);
    chk("stall_if",  32'(bus.stall_if),  32'(bus.if_req && cyc != m_if_ack_c));
    chk("stall_mem", 32'(bus.stall_mem), 32'(bus.mem_ctrl[1] && cyc != m_mem_ack_c));
  endtask

  task automatic model_step();
    bit if_el, mem_el, pick_mem;
    if (rst) begin
      model_reset();
    end else if (m_act) begin
      if (cyc == m_g + LAT) begin
        m_act = 0;
        if (m_own_mem) begin
          m_mem_ack_c = cyc + 1;
          if (!m_we) m_mem_rd = bus.ram_rdata;
        end else begin
          m_if_ack_c = cyc + 1;
          m_if_rd    = bus.ram_rdata;
        end
      end
    end else begin
      if_el  = bus.if_req && (cyc != m_if_ack_c);
      mem_el = bus.mem_ctrl[1] && (cyc != m_mem_ack_c);
      if (if_el || mem_el) begin
        pick_mem   = mem_el && (!if_el || !m_last_mem);
        m_act      = 1;
        m_g        = cyc;
        m_own_mem  = pick_mem;
        m_last_mem = pick_mem;
        m_we       = pick_mem ? bus.mem_ctrl[0] : 1'b0;
        m_addr     = pick_mem ? bus.mem_addr : bus.if_addr;
        m_wdata    = pick_mem ? bus.mem_wdata : 32'h0;
      end
    end
  endtask

  // Called at posedge+1 with this cycle's inputs already applied
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    bus.if_req = 0; bus.if_addr = '0;
    bus.mem_ctrl = 2'b00; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask

  initial begin
    int en_cnt, ack_at, ack_cnt, rises;
    bit prev_en, seen;
    logic [31:0] rd_cap;
    logic [31:0] order [$];
    logic [31:0] exp_addr;

    rst = 1;
    set_idle();
    bus.ram_rdata = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with both requests pending
    bus.if_req = 1; bus.if_addr = 32'h10;
    bus.mem_ctrl = MEM_CTRL_WR_OP; bus.mem_addr = 32'h20; bus.mem_wdata = 32'hCAFE;
    tick();
    tick();
    rst = 0;
    tick();
    chk("first_grant_en", 32'(bus.ram_en), 32'd1);
    chk("first_grant_we", 32'(bus.ram_we), 32'd1);
    set_idle();
    repeat (6) tick();

    // IF read alone
    bus.if_req = 1; bus.if_addr = 32'h40; bus.ram_rdata = 32'hDEADBEEF;
    en_cnt = 0; ack_at = -1; rd_cap = '0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ram_en) en_cnt++;
      if (bus.if_ack) begin ack_at = i; rd_cap = bus.if_rdata; bus.if_req = 0; end
      tick();
    end
    chk("if_en_cycles", 32'(en_cnt), 32'd2);
    chk("if_ack_lat",   32'(ack_at), 32'd3);
    chk("if_rdata_val", rd_cap,      32'hDEADBEEF);

    // Simultaneous held requests alternate MEM/IF
    set_idle();
    repeat (3) tick();
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.mem_ctrl = MEM_CTRL_RD; bus.mem_addr = 32'h300;
    prev_en = 0;
    for (int i = 0; i < 13; i++) begin
      bus.ram_rdata = $urandom;
      if (bus.ram_en && !prev_en) order.push_back(bus.ram_addr);
      prev_en = bus.ram_en;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h300 : 32'h200;
      chk("alt_order", (i < order.size()) ? order[i] : 32'hFFFF_FFFF, exp_addr);
    end

    // Store
    set_idle();
    repeat (4) tick();
    bus.mem_ctrl = MEM_CTRL_WR_OP; bus.mem_addr = 32'h100; bus.mem_wdata = 32'h12345678;
    en_cnt = 0; seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ram_en && bus.ram_we && bus.ram_addr == 32'h100 && bus.ram_wdata == 32'h12345678)
        en_cnt++;
      if (bus.mem_ack) begin seen = 1; bus.mem_ctrl = 2'b00; end
      tick();
    end
    chk("store_cycles", 32'(en_cnt), 32'd2);
    chk("store_ack",    32'(seen),   32'd1);

    // Reset during the second busy cycle of a MEM read
    set_idle();
    repeat (2) tick();
    bus.mem_ctrl = MEM_CTRL_RD; bus.mem_addr = 32'h80;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    set_idle();
    chk("abort_en", 32'(bus.ram_en), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_ack) seen = 1;
      tick();
    end
    chk("abort_no_ack", 32'(seen), 32'd0);

    // Withdrawn IF request still completes, once
    bus.if_req = 1; bus.if_addr = 32'h44; bus.ram_rdata = 32'h0BAD_F00D;
    tick();
    bus.if_req = 0;
    ack_cnt = 0; rises = 0; prev_en = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.if_ack) ack_cnt++;
      if (bus.ram_en && !prev_en) rises++;
      prev_en = bus.ram_en;
      tick();
    end
    chk("wd_ack_count", 32'(ack_cnt), 32'd1);
    chk("wd_no_regrant", 32'(rises), 32'd1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      bus.if_req    = ($urandom_range(0, 2) != 0);
      bus.if_addr   = $urandom;
      bus.mem_ctrl  = 2'($urandom_range(0, 3));
      bus.mem_addr  = $urandom;
      bus.mem_wdata = $urandom;
      bus.ram_rdata = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
